text_console_ctrl: RTL

//   Character-stream controller for the 40-column text-mode display memory.

---
 rtl/text_console_ctrl_if.sv | 22 ++
 rtl/text_console_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl_if.sv
// Byte stream in, text RAM write port out, for the text console controller.
// The slave modport is the controller side; master is the source/RAM side.
interface text_console_ctrl_if #(
    parameter int unsigned ADDR_W = 11
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Character-stream to text RAM writer: cursor tracking, control codes, line wrap
// and hardware scroll via a rotating row_base with clear of the exposed row.
module text_console_ctrl #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 17,
    parameter int unsigned ADDR_W     = 11,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                reset,
    text_console_ctrl_if.slave  bus,
    output logic [4:0]          row_base,
    output logic [5:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic                busy
);
    typedef enum logic [1:0] {StClearAll, StIdle, StClearRow} state_e;

    localparam logic [5:0]        LastCol  = 6'(COLS - 1);
    localparam logic [4:0]        LastRow  = 5'(ROWS - 1);
    localparam logic [5:0]        RowsW    = 6'(ROWS);
    localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [ADDR_W-1:0] clr_base_q, clr_base_d;
    logic [4:0]        row_base_q, row_base_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              printable;
    logic              do_newline;
    logic [5:0]        row_sum;
    logic [4:0]        phys_row;
    logic [ADDR_W-1:0] cur_addr;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    // Display row -> physical row; both operands < ROWS so one subtract suffices.
    assign row_sum  = {1'b0, row_base_q} + {1'b0, row_q};
    assign phys_row = (row_sum >= RowsW) ? 5'(row_sum - RowsW) : row_sum[4:0];
    assign cur_addr = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col_q);

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        clr_base_d  = clr_base_q;
        row_base_d  = row_base_q;
        col_d       = col_q;
        row_d       = row_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        do_newline  = 1'b0;

        unique case (state_q)
            StClearAll: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = clr_idx_q;
                mem_wdata_d = CLEAR_CHAR;
                if (clr_idx_q == LastCell) begin
                    clr_idx_d = '0;
                    state_d   = StIdle;
                end else begin
                    clr_idx_d = clr_idx_q + AddrOne;
                end
            end
            StClearRow: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = clr_base_q + clr_idx_q;
                mem_wdata_d = CLEAR_CHAR;
                if (clr_idx_q == LastIdx) begin
                    clr_idx_d = '0;
                    state_d   = StIdle;
                end else begin
                    clr_idx_d = clr_idx_q + AddrOne;
                end
            end
            StIdle: begin
                if (accept) begin
                    if (printable) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = cur_addr;
                        mem_wdata_d = bus.in_data;
                        if (col_q == LastCol) begin
                            col_d      = '0;
                            do_newline = 1'b1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d      = '0;
                                do_newline = 1'b1;
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d       = col_q - 6'd1;
                                    mem_we_d    = 1'b1;
                                    mem_waddr_d = cur_addr - AddrOne;
                                    mem_wdata_d = CLEAR_CHAR;
                                end
                            end
                            8'h0C: begin
                                col_d      = '0;
                                row_d      = '0;
                                row_base_d = '0;
                                clr_idx_d  = '0;
                                state_d    = StClearAll;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = StClearAll;
        endcase

        // Newline on the last row scrolls: the old top row becomes the new bottom.
        if (do_newline) begin
            if (row_q != LastRow) begin
                row_d = row_q + 5'd1;
            end else begin
                row_base_d = (row_base_q == LastRow) ? 5'd0 : row_base_q + 5'd1;
                clr_base_d = ADDR_W'(row_base_q) * ADDR_W'(COLS);
                clr_idx_d  = '0;
                state_d    = StClearRow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClearAll;
            clr_idx_q   <= '0;
            clr_base_q  <= '0;
            row_base_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            clr_base_q  <= clr_base_d;
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign row_base      = row_base_q;
    assign cursor_col    = col_q;
    assign cursor_row    = row_q;
    assign busy          = (state_q != StIdle);
endmodule
